// File: rtl/face_pkg.sv
// Purpose: shared widths and FSM state type for the face-detection datapath.
// Contents: default pixel/sum/frame-width parameters, dimension port width, state enum.
package face_pkg;

  localparam int unsigned DEF_PIX_W = 8;
  localparam int unsigned DEF_SUM_W = 32;
  localparam int unsigned DEF_MAX_W = 1024;
  localparam int unsigned DIM_W     = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ii_line_buf.sv
// Purpose: one-row line buffer holding the previous row's integral values.
// Ports: i_clk clock; i_we write enable; i_addr column index;
//        i_wdata write data; o_rdata combinational read of i_addr.
// Contents are never reset; row 0 ignores whatever is stored here.
module ii_line_buf #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 10
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  // Read-before-write within a cycle: read is combinational, write lands at the edge.
  assign o_rdata = r_mem[i_addr];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

endmodule

// File: rtl/integral_image_gen.sv
// Purpose: streaming integral (summed-area) image generator, raster in / raster out.
// Ports: i_clk, i_reset (async, active-low); i_start/i_width/i_height frame setup;
//        i_pix_valid/i_pix_data/o_pix_ready pixel input; o_ii_valid/o_ii_data/
//        o_ii_last/i_ii_ready integral output; o_busy, o_done, o_err, o_overflow status.
module integral_image_gen
  import face_pkg::*;
#(
  parameter int unsigned MAX_W = DEF_MAX_W,
  parameter int unsigned PIX_W = DEF_PIX_W,
  parameter int unsigned SUM_W = DEF_SUM_W
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [DIM_W-1:0] i_width,
  input  logic [DIM_W-1:0] i_height,
  input  logic             i_pix_valid,
  input  logic [PIX_W-1:0] i_pix_data,
  output logic             o_pix_ready,
  output logic             o_ii_valid,
  output logic [SUM_W-1:0] o_ii_data,
  input  logic             i_ii_ready,
  output logic             o_ii_last,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic             o_overflow
);

  localparam int unsigned AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  state_t           r_state;
  logic [DIM_W-1:0] r_w;
  logic [DIM_W-1:0] r_h;
  logic [DIM_W-1:0] r_x;
  logic [DIM_W-1:0] r_y;
  logic [SUM_W-1:0] r_row_sum;
  logic             r_last_sent;
  logic             r_ii_valid;
  logic [SUM_W-1:0] r_ii_data;
  logic             r_ii_last;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             r_overflow;

  logic             w_accept;
  logic             w_hs;
  logic             w_x_end;
  logic             w_y_end;
  logic             w_dims_ok;
  logic [SUM_W-1:0] w_lbuf_rd;
  logic [SUM_W-1:0] w_above;
  logic [SUM_W:0]   w_rs_ext;
  logic [SUM_W:0]   w_res_ext;

  // Intake is gated by output backpressure and stops once the last word is captured.
  assign o_pix_ready = (r_state == S_RUN) && !r_last_sent && (!r_ii_valid || i_ii_ready);
  assign w_accept    = i_pix_valid && o_pix_ready;
  assign w_hs        = r_ii_valid && i_ii_ready;

  assign w_x_end   = (r_x == r_w - DIM_W'(1));
  assign w_y_end   = (r_y == r_h - DIM_W'(1));
  assign w_dims_ok = (i_width != '0) && (i_width <= DIM_W'(MAX_W)) && (i_height != '0);

  // Extra MSB on each adder captures the carry-out feeding the sticky overflow flag.
  assign w_above   = (r_y == '0) ? '0 : w_lbuf_rd;
  assign w_rs_ext  = {1'b0, r_row_sum} + (SUM_W+1)'(i_pix_data);
  assign w_res_ext = {1'b0, w_rs_ext[SUM_W-1:0]} + {1'b0, w_above};

  ii_line_buf #(
    .DEPTH (MAX_W),
    .DW    (SUM_W),
    .AW    (AW)
  ) u_lbuf (
    .i_clk   (i_clk),
    .i_we    (w_accept),
    .i_addr  (r_x[AW-1:0]),
    .i_wdata (w_res_ext[SUM_W-1:0]),
    .o_rdata (w_lbuf_rd)
  );

  // Frame control FSM plus registered output stage.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_w         <= '0;
      r_h         <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_row_sum   <= '0;
      r_last_sent <= 1'b0;
      r_ii_valid  <= 1'b0;
      r_ii_data   <= '0;
      r_ii_last   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (w_dims_ok) begin
              r_state     <= S_RUN;
              r_w         <= i_width;
              r_h         <= i_height;
              r_x         <= '0;
              r_y         <= '0;
              r_row_sum   <= '0;
              r_overflow  <= 1'b0;
              r_last_sent <= 1'b0;
              r_busy      <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_ii_valid <= 1'b1;
            r_ii_data  <= w_res_ext[SUM_W-1:0];
            r_ii_last  <= w_x_end && w_y_end;
            r_overflow <= r_overflow | w_rs_ext[SUM_W] | w_res_ext[SUM_W];
            if (w_x_end && w_y_end) r_last_sent <= 1'b1;
            if (w_x_end) begin
              r_x       <= '0;
              r_row_sum <= '0;
              r_y       <= r_y + DIM_W'(1);
            end else begin
              r_x       <= r_x + DIM_W'(1);
              r_row_sum <= w_rs_ext[SUM_W-1:0];
            end
          end else if (w_hs) begin
            r_ii_valid <= 1'b0;
            if (r_ii_last) begin
              r_ii_last <= 1'b0;
              r_state   <= S_DONE;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ii_valid = r_ii_valid;
  assign o_ii_data  = r_ii_data;
  assign o_ii_last  = r_ii_last;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_overflow = r_overflow;

endmodule
